mem_arbiter: RTL and testbench

- Sits between the requesters (instruction cache, load/store buffer, optional instruction prefetcher) and the byte-serial memory controller.
- Selects one request at a time and presents it on a single request/response channel.
- Owns grant policy, starvation avoidance and flush-time cancellation, so the memory controller only ever sees one stable request.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, transaction owners and access sizes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_LSB  = 2'd2,
    OWN_PF   = 2'd3
  } owner_e;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: LSB > IC > PF, with IC forced ahead of LSB once it has starved.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   ic_req,
  input  logic   lsb_req,
  input  logic   pf_req,
  input  logic   flush,
  input  logic   starve_sat,
  output owner_e owner_c
);

  logic ic_ok;
  logic pf_ok;

  // Flush makes instruction-side requests ineligible for this decision only.
  assign ic_ok = ic_req & ~flush;
  assign pf_ok = pf_req & ~flush & ~ic_req & ~lsb_req;

  always_comb begin
    owner_c = OWN_NONE;
    if (ic_ok && starve_sat) begin
      owner_c = OWN_IC;
    end else if (lsb_req) begin
      owner_c = OWN_LSB;
    end else if (ic_ok) begin
      owner_c = OWN_IC;
    end else if (pf_ok) begin
      owner_c = OWN_PF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-channel arbiter in front of the byte-serial memory controller.
// Define MEM_ARB_PREFETCH_EN to make the prefetch port live; otherwise pf_req is ignored.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_rdata,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_size,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_done,
  output logic [31:0] pf_rdata,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [2:0]  mc_size,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_valid_q, mc_valid_d;
  logic             mc_wr_q, mc_wr_d;
  logic [31:0]      mc_addr_q, mc_addr_d;
  logic [2:0]       mc_size_q, mc_size_d;
  logic [31:0]      mc_wdata_q, mc_wdata_d;
  logic             ic_done_q, ic_done_d;
  logic [31:0]      ic_rdata_q, ic_rdata_d;
  logic             lsb_done_q, lsb_done_d;
  logic [31:0]      lsb_rdata_q, lsb_rdata_d;
  logic             pf_done_q, pf_done_d;
  logic [31:0]      pf_rdata_q, pf_rdata_d;

  logic   pf_req_c;
  logic   starve_sat_c;
  logic   drop_now_c;
  owner_e pick_c;

`ifdef MEM_ARB_PREFETCH_EN
  assign pf_req_c = pf_req;
`else
  // Prefetch port is present but inert; owner can never become PF.
  logic pf_unused;
  assign pf_unused = pf_req;
  assign pf_req_c  = 1'b0;
`endif

  assign starve_sat_c = (cnt_q >= CNT_W'(STARVE_LIMIT));
  // A flush in the completion cycle itself must still suppress the done pulse.
  assign drop_now_c   = drop_q | (flush & ((owner_q == OWN_IC) | (owner_q == OWN_PF)));

  mem_arb_pick u_pick (
    .ic_req     (ic_req),
    .lsb_req    (lsb_req),
    .pf_req     (pf_req_c),
    .flush      (flush),
    .starve_sat (starve_sat_c),
    .owner_c    (pick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      mc_valid_q  <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_size_q   <= '0;
      mc_wdata_q  <= '0;
      ic_done_q   <= 1'b0;
      ic_rdata_q  <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
      pf_done_q   <= 1'b0;
      pf_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      mc_valid_q  <= mc_valid_d;
      mc_wr_q     <= mc_wr_d;
      mc_addr_q   <= mc_addr_d;
      mc_size_q   <= mc_size_d;
      mc_wdata_q  <= mc_wdata_d;
      ic_done_q   <= ic_done_d;
      ic_rdata_q  <= ic_rdata_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      pf_done_q   <= pf_done_d;
      pf_rdata_q  <= pf_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    mc_valid_d  = mc_valid_q;
    mc_wr_d     = mc_wr_q;
    mc_addr_d   = mc_addr_q;
    mc_size_d   = mc_size_q;
    mc_wdata_d  = mc_wdata_q;
    ic_done_d   = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    pf_done_d   = 1'b0;
    pf_rdata_d  = pf_rdata_q;

    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          drop_d = 1'b0;
          if (ic_req && (pick_c == OWN_LSB)) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end else if (!ic_req || (pick_c == OWN_IC)) begin
            cnt_d = '0;
          end
          if (pick_c != OWN_NONE) begin
            state_d    = ST_BUSY;
            owner_d    = pick_c;
            mc_valid_d = 1'b1;
            mc_wr_d    = 1'b0;
            mc_size_d  = SZ_WORD;
            mc_wdata_d = '0;
            case (pick_c)
              OWN_IC:  mc_addr_d = ic_addr;
              OWN_PF:  mc_addr_d = pf_addr;
              default: begin
                mc_wr_d    = lsb_wr;
                mc_addr_d  = lsb_addr;
                mc_size_d  = lsb_size;
                mc_wdata_d = lsb_wdata;
              end
            endcase
          end
        end
        ST_BUSY: begin
          drop_d = drop_now_c;
          if (mc_done) begin
            mc_valid_d = 1'b0;
            state_d    = ST_TURN;
            if (!drop_now_c) begin
              case (owner_q)
                OWN_IC:  begin ic_done_d  = 1'b1; ic_rdata_d  = mc_rdata; end
                OWN_LSB: begin lsb_done_d = 1'b1; lsb_rdata_d = mc_rdata; end
                OWN_PF:  begin pf_done_d  = 1'b1; pf_rdata_d  = mc_rdata; end
                default: ;
              endcase
            end
          end
        end
        ST_TURN: begin
          drop_d  = 1'b0;
          owner_d = OWN_NONE;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ic_done   = ic_done_q;
  assign ic_rdata  = ic_rdata_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign pf_done   = pf_done_q;
  assign pf_rdata  = pf_rdata_q;
  assign mc_valid  = mc_valid_q;
  assign mc_wr     = mc_wr_q;
  assign mc_addr   = mc_addr_q;
  assign mc_size   = mc_size_q;
  assign mc_wdata  = mc_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the initial block plays requesters and memory controller.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        ic_req, ic_done;
  logic [31:0] ic_addr, ic_rdata;
  logic        lsb_req, lsb_wr, lsb_done;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [2:0]  lsb_size;
  logic        pf_req, pf_done;
  logic [31:0] pf_addr, pf_rdata;
  logic        mc_valid, mc_wr, mc_done;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;
  logic [2:0]  mc_size;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_LIMIT(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_rdata(pf_rdata),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_size(mc_size),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle-output snapshot: no request pending and no done pulses.
  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(mc_valid), 32'd0);
    chk({tag, "_dones"}, 32'({ic_done, lsb_done, pf_done}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
    pf_req = 1'b0; pf_addr = '0;
    mc_done = 1'b0; mc_rdata = '0;
    tick(); tick();
    chk_quiet("reset");
    chk("reset_addr", mc_addr, 32'h0);
    chk("reset_size", 32'(mc_size), 32'd0);
    chk("reset_ic_rdata", ic_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // IC fetch, completion five cycles after grant
    ic_req = 1'b1; ic_addr = 32'h100;
    tick();
    chk("ic_valid", 32'(mc_valid), 32'd1);
    chk("ic_addr", mc_addr, 32'h100);
    chk("ic_size", 32'(mc_size), 32'(SZ_WORD));
    chk("ic_wr", 32'(mc_wr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ic_hold", {31'd0, mc_valid}, 32'd1);
    end
    mc_done = 1'b1; mc_rdata = 32'hDEADBEEF;
    tick();
    mc_done = 1'b0; ic_req = 1'b0;
    chk("ic_done", 32'(ic_done), 32'd1);
    chk("ic_rdata", ic_rdata, 32'hDEADBEEF);
    chk("ic_done_valid", 32'(mc_valid), 32'd0);
    tick();
    chk_quiet("ic_turn");
    tick();
    chk_quiet("ic_idle");

    // Simultaneous IC fetch and LSB byte store: store first
    ic_req = 1'b1; ic_addr = 32'h200;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_size = SZ_BYTE; lsb_wdata = 32'hAB;
    tick();
    chk("st_valid", 32'(mc_valid), 32'd1);
    chk("st_wr", 32'(mc_wr), 32'd1);
    chk("st_addr", mc_addr, 32'h30000);
    chk("st_size", 32'(mc_size), 32'(SZ_BYTE));
    chk("st_wdata", mc_wdata, 32'hAB);
    mc_done = 1'b1; mc_rdata = 32'h0;
    tick();
    mc_done = 1'b0; lsb_req = 1'b0;
    chk("st_done", 32'({ic_done, lsb_done}), 32'b01);
    tick();
    chk_quiet("st_turn");
    tick();
    chk("ic2_valid", 32'(mc_valid), 32'd1);
    chk("ic2_addr", mc_addr, 32'h200);
    chk("ic2_wr", 32'(mc_wr), 32'd0);
    mc_done = 1'b1; mc_rdata = 32'h12345678;
    tick();
    mc_done = 1'b0; ic_req = 1'b0;
    chk("ic2_done", 32'({ic_done, lsb_done}), 32'b10);
    chk("ic2_rdata", ic_rdata, 32'h12345678);
    tick(); tick();

    // Starvation with limit 2: LSB, LSB, forced IC, then LSB again
    ic_req = 1'b1; ic_addr = 32'h300;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h400; lsb_size = SZ_WORD; lsb_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sv_lsb_addr", mc_addr, 32'h400);
      chk("sv_lsb_valid", {31'd0, mc_valid}, 32'd1);
      mc_done = 1'b1; mc_rdata = 32'hCAFE0000 + 32'(k);
      tick();
      mc_done = 1'b0;
      chk("sv_lsb_done", 32'({ic_done, lsb_done}), 32'b01);
      chk("sv_lsb_rdata", lsb_rdata, 32'hCAFE0000 + 32'(k));
      tick();
    end
    tick();
    chk("sv_force_ic", mc_addr, 32'h300);
    chk("sv_force_wr", 32'(mc_wr), 32'd0);
    mc_done = 1'b1; mc_rdata = 32'h0BADF00D;
    tick();
    mc_done = 1'b0;
    chk("sv_ic_done", 32'({ic_done, lsb_done}), 32'b10);
    tick(); tick();
    chk("sv_cnt_clear", mc_addr, 32'h400);
    mc_done = 1'b1; mc_rdata = 32'h0;
    tick();
    mc_done = 1'b0; lsb_req = 1'b0; ic_req = 1'b0;
    chk("sv_last_done", 32'(lsb_done), 32'd1);
    tick(); tick();

    // Flush during IC transaction: no ic_done, pending store granted next
    ic_req = 1'b1; ic_addr = 32'h500;
    tick();
    chk("fl_ic_addr", mc_addr, 32'h500);
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h600; lsb_size = SZ_HALF; lsb_wdata = 32'hBEEF;
    flush = 1'b1;
    tick();
    flush = 1'b0; ic_req = 1'b0;
    chk("fl_busy_valid", 32'(mc_valid), 32'd1);
    mc_done = 1'b1; mc_rdata = 32'hFFFFFFFF;
    tick();
    mc_done = 1'b0;
    chk_quiet("fl_dropped");
    tick();
    chk_quiet("fl_turn");
    tick();
    chk("fl_lsb_addr", mc_addr, 32'h600);
    chk("fl_lsb_wr", 32'(mc_wr), 32'd1);
    chk("fl_lsb_size", 32'(mc_size), 32'(SZ_HALF));
    mc_done = 1'b1; mc_rdata = 32'h0;
    tick();
    mc_done = 1'b0; lsb_req = 1'b0;
    chk("fl_lsb_done", 32'({ic_done, lsb_done}), 32'b01);
    tick(); tick();

    // rdy low for 3 cycles in BUSY while the controller holds mc_done
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h700; lsb_size = SZ_HALF;
    tick();
    chk("rdy_grant", mc_addr, 32'h700);
    rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'h0000BEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_frz_valid", {31'd0, mc_valid}, 32'd1);
      chk("rdy_frz_addr", mc_addr, 32'h700);
      chk("rdy_frz_done", {31'd0, lsb_done}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    mc_done = 1'b0; lsb_req = 1'b0;
    chk("rdy_done", 32'(lsb_done), 32'd1);
    chk("rdy_rdata", lsb_rdata, 32'h0000BEAD);
    chk("rdy_valid", 32'(mc_valid), 32'd0);
    tick(); tick();

    // Prefetch request alone
    pf_req = 1'b1; pf_addr = 32'h800;
    tick();
`ifdef MEM_ARB_PREFETCH_EN
    chk("pf_valid", 32'(mc_valid), 32'd1);
    chk("pf_addr", mc_addr, 32'h800);
    mc_done = 1'b1; mc_rdata = 32'h5A5A5A5A;
    tick();
    mc_done = 1'b0; pf_req = 1'b0;
    chk("pf_done", 32'({ic_done, lsb_done, pf_done}), 32'b001);
    chk("pf_rdata", pf_rdata, 32'h5A5A5A5A);
    tick(); tick();
`else
    chk_quiet("pf_off1");
    tick();
    chk_quiet("pf_off2");
    chk("pf_off_rdata", pf_rdata, 32'h0);
    pf_req = 1'b0;
    tick();
`endif

    // Reset in the middle of a transaction
    ic_req = 1'b1; ic_addr = 32'h900;
    tick();
    chk("rst_mid_valid", 32'(mc_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ic_req = 1'b0;
    chk_quiet("rst_mid");
    chk("rst_mid_addr", mc_addr, 32'h0);
    chk("rst_mid_rdata", lsb_rdata, 32'h0);
    tick();
    chk_quiet("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
